mem_access: RTL



---
 rtl/mem_access.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory stage of the five-stage RV32I_Zicsr pipeline.
//
// Takes execute's registered outputs, issues one load or store at a time on
// a req/ack data-memory port, and hands the result to writeback one register
// later. Memory accesses are byte-laned (replicated store data plus byte
// enables). Load data is extracted and extended from the returned word.
// Misaligned or undecodable accesses never reach the bus. They raise a
// one-cycle flag instead.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_opcode/i_funct3       instruction class and access size/sign
//   i_alu_result            effective address (mem ops) or ALU result
//   i_rs2_data              store data
//   i_rd_addr/i_rd_wr_en    destination register and its write enable
//   i_pc                    instruction PC
//   i_flush                 turn the current IDLE-cycle instruction into a bubble
//   o_dmem_*                registered data-memory request (word address)
//   i_dmem_ack/i_dmem_rdata transfer completion and read word
//   or_*                    registered results to writeback
//   ow_stall                combinational hold for upstream stages
//   ow_fwd_*                forwarding of the ALU result back to execute
module mem_access #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5,
  parameter int OPLEN = 7,
  parameter logic [OPLEN-1:0] L_OP = 7'b0000011,
  parameter logic [OPLEN-1:0] S_OP = 7'b0100011
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OPLEN-1:0] i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_wr_en,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [XLEN-1:0]  o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic [OPLEN-1:0] or_opcode,
  output logic [XLEN-1:0]  or_rd_data,
  output logic [XADDR-1:0] or_rd_addr,
  output logic             or_rd_wr_en,
  output logic [XLEN-1:0]  or_pc,
  output logic             or_misaligned,
  output logic             or_illegal,
  output logic             ow_stall,
  output logic [XLEN-1:0]  ow_fwd_data,
  output logic [XADDR-1:0] ow_fwd_addr,
  output logic             ow_fwd_wr_en
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic       is_load, is_store, funct3_ok, aligned, mem_op;
  logic [1:0] off;

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                               input logic [1:0] ofs,
                                               input logic [XLEN-1:0] word);
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] wide;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    wide = b;
      3'd1:    wide = h;
      3'd4:    wide = $signed({{(XLEN-8){1'b0}}, b});
      3'd5:    wide = $signed({{(XLEN-16){1'b0}}, h});
      default: wide = $signed(word);
    endcase
    return $unsigned(wide);
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] ofs);
    case (f3[1:0])
      2'd0:    return 4'b0001 << ofs;
      2'd1:    return 4'b0011 << {ofs[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] rs2);
    case (f3[1:0])
      2'd0:    return {4{rs2[7:0]}};
      2'd1:    return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  assign is_load  = (i_opcode == L_OP);
  assign is_store = (i_opcode == S_OP);
  assign off      = i_alu_result[1:0];

  always_comb begin
    funct3_ok = 1'b0;
    if (is_load)
      funct3_ok = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                  (i_funct3 == 3'd4) || (i_funct3 == 3'd5);
    else if (is_store)
      funct3_ok = (i_funct3 <= 3'd2);
  end

  always_comb begin
    aligned = 1'b1;
    case (i_funct3[1:0])
      2'd1:    aligned = ~off[0];
      2'd2:    aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign mem_op = (is_load || is_store) && funct3_ok && aligned;

  // Upstream is released on the ack edge itself, so the completed op is not reissued.
  assign ow_stall     = mem_op && !(state == S_WAIT && i_dmem_ack);
  assign ow_fwd_data  = i_alu_result;
  assign ow_fwd_addr  = i_rd_addr;
  assign ow_fwd_wr_en = i_rd_wr_en && !is_load;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_op && !i_flush) state_nxt = S_WAIT;
      S_WAIT:  if (i_dmem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ---- memory -> writeback register boundary ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_dmem_req    <= 1'b0;
      o_dmem_we     <= 1'b0;
      o_dmem_addr   <= '0;
      o_dmem_be     <= '0;
      o_dmem_wdata  <= '0;
      or_opcode     <= '0;
      or_rd_data    <= '0;
      or_rd_addr    <= '0;
      or_rd_wr_en   <= 1'b0;
      or_pc         <= '0;
      or_misaligned <= 1'b0;
      or_illegal    <= 1'b0;
    end else begin
      or_misaligned <= 1'b0;
      or_illegal    <= 1'b0;
      if (state == S_IDLE) begin
        or_rd_data <= i_alu_result;
        or_rd_addr <= i_rd_addr;
        or_pc      <= i_pc;
        if (i_flush) begin
          or_opcode   <= '0;
          or_rd_wr_en <= 1'b0;
        end else if (mem_op) begin
          o_dmem_req   <= 1'b1;
          o_dmem_we    <= is_store;
          o_dmem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
          o_dmem_be    <= is_store ? store_be(i_funct3, off) : 4'b1111;
          o_dmem_wdata <= store_data(i_funct3, i_rs2_data);
          or_opcode    <= '0;
          or_rd_wr_en  <= 1'b0;
        end else if (is_load || is_store) begin
          // Faulting access: report it, never touch the bus or the register file.
          or_opcode     <= i_opcode;
          or_rd_wr_en   <= 1'b0;
          or_illegal    <= !funct3_ok;
          or_misaligned <= funct3_ok && !aligned;
        end else begin
          or_opcode   <= i_opcode;
          or_rd_wr_en <= i_rd_wr_en;
        end
      end else if (i_dmem_ack) begin
        o_dmem_req  <= 1'b0;
        o_dmem_we   <= 1'b0;
        o_dmem_be   <= '0;
        or_opcode   <= i_opcode;
        or_rd_data  <= is_load ? load_ext(i_funct3, off, i_dmem_rdata) : i_alu_result;
        or_rd_addr  <= i_rd_addr;
        or_pc       <= i_pc;
        or_rd_wr_en <= is_load && i_rd_wr_en;
      end else begin
        // Transfer outstanding: writeback sees bubbles, bus signals held.
        or_opcode   <= '0;
        or_rd_wr_en <= 1'b0;
      end
    end
  end

endmodule
